ps2_mode_controller: RTL and testbench
======================================

# ps2_mode_controller

Parametrised keyboard mode sequencer for the step sequencer front panel. It consumes the PS/2 receive byte stream and steps through IDLE and NUM_MODES one-hot modes. Make codes are forwarded to the active mode's input decoder, with commit, cancel and entry pulses plus per-mode blink LEDs. It replaces the fixed loop/BPM/move/play state machine and adds break/extended-prefix filtering, an idle timeout and an optional ESC cancel.

## Interface
- NUM_MODES, 4: number of modes (1–8).
- MODE_KEYS, {8'h29,8'h3A,8'h32,8'h4B}: NUM_MODES×8 bits; byte i (bits 8i+7:8i) is the entry make code of mode i.
- HOLD_MASK, 4'b1000: bit i set means mode i is a hold mode (exits on hold_active release); clear means an edit mode (exits on ENTER 8'h5A).
- BLINK_DIV, 1_250_000: clock cycles per LED blink phase.
- TIMEOUT_CYC, 0: edit-mode inactivity limit in cycles; 0 disables the timeout.

Ports:
- CLOCK_50  in  1  system clock; all logic on posedge.
- nReset  in  1  synchronous, active-low reset.
- rx_data  in  8  PS/2 received byte.
- rx_en  in  1  single-cycle strobe; rx_data is valid when high.
- hold_active  in  1  consumer busy flag for hold modes.
- mode  out  NUM_MODES  one-hot active mode; all zeros = IDLE.
- entry  out  NUM_MODES  one-cycle pulse on entering mode i.
- commit  out  NUM_MODES  one-cycle pulse on exiting mode i by ENTER or hold release.
- cancel  out  NUM_MODES  one-cycle pulse on exiting mode i by timeout or ESC.
- key_data  out  8  forwarded make code.
- key_ext  out  1  high when key_data was preceded by E0.
- key_valid  out  1  one-cycle pulse; key_data/key_ext valid.
- led  out  NUM_MODES  1 for inactive modes; blink phase for the active mode.

## Operation
- Prefix filter:
  - 8'hE0 sets the ext flag. 8'hF0 sets the brk flag. Neither prefix is forwarded or acted on.
  - The next non-prefix byte clears both flags.
  - If brk was set, that byte is discarded entirely: no transition, no forward. This applies to E0 F0 xx as well.
- IDLE:
  - A non-break byte equal to MODE_KEYS byte i enters mode i. If several entries match, the lowest index wins.
  - All other bytes are ignored. Nothing is forwarded in IDLE.
- Edit mode:
  - ENTER produces a commit pulse and returns to IDLE.
  - Every other non-break byte is forwarded: key_valid pulses, key_ext = ext flag. Other modes' entry keys are forwarded as data and do not switch modes.
  - The entry byte and the ENTER byte are never forwarded.
- Hold mode:
  - Bytes are ignored.
  - The mode arms on the first cycle hold_active is high.
  - Once armed, the first cycle with hold_active low produces a commit pulse and returns to IDLE.
- Timeout:
  - A 32-bit counter clears on mode entry and on every rx_en.
  - In an edit mode, when the counter reaches TIMEOUT_CYC (nonzero), the block produces a cancel pulse and returns to IDLE.
- Blink:
  - A free-running counter runs 0..BLINK_DIV-1. At the terminal count it wraps to 0 and the phase toggles.
  - led[i] = phase when mode[i] is set, else 1.

## Timing
- All outputs are registered. An event in cycle t (rx_en, a hold_active edge, or a timeout hit) appears on mode/entry/commit/cancel/key_* in cycle t+1.
- Pulses last exactly one cycle. key_data/key_ext hold their value until the next key_valid.
- Reset values:
  - mode, entry, commit, cancel, key_data, key_ext, key_valid, led: 0.
  - Flags, armed bit, counters, blink phase: 0.
  - In IDLE, led goes to all ones on the first clock after reset.
- Reset asserted mid-sequence discards pending prefixes and the active mode, with no pulses.
- Simultaneous events:
  - ENTER and timeout in the same cycle: commit wins.
  - Hold release and rx_en in the same cycle: commit wins and the byte is dropped.
  - Entry and exit never occur in the same cycle.

## Configuration
- KEY_CANCEL_EN defined:
  - A non-break ESC (8'h76) in any mode produces a cancel pulse for that mode and returns to IDLE, without being forwarded.
  - In a hold mode, ESC cancels even when the mode is unarmed.
- KEY_CANCEL_EN undefined:
  - 8'h76 is forwarded in edit modes and ignored in hold modes.
  - cancel pulses only from the timeout.

## Test plan
- Reset, then rx 4B, 16, 1E, 5A → entry[0] pulse; mode=0001; key_valid twice (16, 1E); commit[0] pulse; mode=0000.
- In mode 1, rx F0 16, E0 75 → 16 not forwarded; key_data=75 with key_ext=1; mode remains 0010.
- Rx 29 with hold_active low for 10 cycles, then high for 5, then low → mode=1000 until the cycle after hold_active falls; commit[3] pulse; no early exit.
- TIMEOUT_CYC=100, rx 32 and then nothing → cancel[1] exactly 100 cycles after the last rx_en (+1 for the register); mode=0000.
- With KEY_CANCEL_EN, rx 3A, 76 → cancel[2]; key_valid never asserts. Without KEY_CANCEL_EN → key_data=76; mode stays 0100.
- BLINK_DIV=4 in mode 0 → led[0] toggles every 4 cycles; led[3:1]=111. Assert nReset mid-blink → all outputs 0 the next cycle.

Source files
------------

// File: rtl/ps2_mode_controller.sv
// ----------------------------------------------------------------------------
// ps2_mode_controller
//
// Keyboard mode sequencer for the step sequencer front panel. Watches the
// PS/2 receive byte stream and moves between IDLE and NUM_MODES one-hot
// modes. Edit modes forward make codes to the mode's decoder and leave on
// ENTER (commit). Hold modes ignore bytes and leave when the consumer's
// hold_active flag drops after having been seen high (commit). Break codes
// (F0 xx, E0 F0 xx) are swallowed; an E0 prefix is reported via key_ext.
//
// Optional feature (compile-time macro KEY_CANCEL_EN):
//   defined   - a non-break ESC (8'h76) cancels the active mode (cancel pulse)
//   undefined - ESC is ordinary data; cancel only comes from the timeout
//
// Parameters:
//   NUM_MODES    number of modes (1..8)
//   MODE_KEYS    byte i = entry make code of mode i
//   HOLD_MASK    bit i set = mode i is a hold mode, else an edit mode
//   BLINK_DIV    clock cycles per LED blink phase
//   TIMEOUT_CYC  edit-mode inactivity limit in cycles, 0 = no timeout
//
// Ports:
//   CLOCK_50     system clock, rising edge
//   nReset       synchronous active-low reset
//   rx_data      received PS/2 byte, valid while rx_en is high
//   rx_en        single-cycle receive strobe
//   hold_active  consumer busy flag, watched in hold modes
//   mode         one-hot active mode, zero = IDLE
//   entry        one-cycle pulse on entering mode i
//   commit       one-cycle pulse on leaving mode i by ENTER / hold release
//   cancel       one-cycle pulse on leaving mode i by timeout / ESC
//   key_data     forwarded make code (held until next key_valid)
//   key_ext      key_data was preceded by E0
//   key_valid    one-cycle pulse qualifying key_data / key_ext
//   led          1 for inactive modes, blink phase for the active mode
// ----------------------------------------------------------------------------
module ps2_mode_controller #(
    parameter int                       NUM_MODES   = 4,
    parameter logic [NUM_MODES*8-1:0]   MODE_KEYS   = {8'h29, 8'h3A, 8'h32, 8'h4B},
    parameter logic [NUM_MODES-1:0]     HOLD_MASK   = 4'b1000,
    parameter int                       BLINK_DIV   = 1_250_000,
    parameter int unsigned              TIMEOUT_CYC = 0
) (
    input  logic                    CLOCK_50,
    input  logic                    nReset,
    input  logic [7:0]              rx_data,
    input  logic                    rx_en,
    input  logic                    hold_active,
    output logic [NUM_MODES-1:0]    mode,
    output logic [NUM_MODES-1:0]    entry,
    output logic [NUM_MODES-1:0]    commit,
    output logic [NUM_MODES-1:0]    cancel,
    output logic [7:0]              key_data,
    output logic                    key_ext,
    output logic                    key_valid,
    output logic [NUM_MODES-1:0]    led
);

    localparam int IDX_W = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1;
    localparam int BW    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
    localparam bit   TO_EN = (TIMEOUT_CYC != 0);

    localparam logic [7:0] K_EXT   = 8'hE0;
    localparam logic [7:0] K_BRK   = 8'hF0;
    localparam logic [7:0] K_ENTER = 8'h5A;
`ifdef KEY_CANCEL_EN
    localparam logic [7:0] K_ESC   = 8'h76;
`endif

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EDIT,
        ST_HOLD
    } state_t;

    function automatic logic [NUM_MODES-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_MODES-1:0] o;
        o = '0;
        for (int i = 0; i < NUM_MODES; i++)
            if (idx == IDX_W'(i)) o[i] = 1'b1;
        return o;
    endfunction

    // ---------------- state ----------------
    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               armed_q, armed_d;
    logic               ext_q, ext_d;
    logic               brk_q, brk_d;
    logic [31:0]        to_cnt_q, to_cnt_d;
    logic [BW-1:0]      blink_cnt_q, blink_cnt_d;
    logic               phase_q, phase_d;

    logic [NUM_MODES-1:0] mode_d, entry_d, commit_d, cancel_d, led_d;
    logic [7:0]           key_data_d;
    logic                 key_ext_d, key_valid_d;

    // ---------------- byte classification ----------------
    logic is_ext, is_brk, key_evt;
    assign is_ext  = rx_en && (rx_data == K_EXT);
    assign is_brk  = rx_en && (rx_data == K_BRK);
    // A real make code: not a prefix and not the tail of a break sequence.
    assign key_evt = rx_en && !is_ext && !is_brk && !brk_q;

    logic [NUM_MODES-1:0] key_match;
    genvar g;
    generate
        for (g = 0; g < NUM_MODES; g++) begin : g_match
            assign key_match[g] = key_evt && (rx_data == MODE_KEYS[8*g +: 8]);
        end
    endgenerate

    // Lowest matching index wins.
    logic             match_any;
    logic [IDX_W-1:0] match_idx;
    always_comb begin
        match_any = 1'b0;
        match_idx = '0;
        for (int i = NUM_MODES - 1; i >= 0; i--) begin
            if (key_match[i]) begin
                match_any = 1'b1;
                match_idx = IDX_W'(i);
            end
        end
    end

    logic to_hit;
    assign to_hit = TO_EN && (to_cnt_q == 32'(TIMEOUT_CYC));

    // ---------------- prefix flags ----------------
    always_comb begin
        ext_d = ext_q;
        brk_d = brk_q;
        if (rx_en) begin
            if (is_ext) begin
                ext_d = 1'b1;
            end else if (is_brk) begin
                brk_d = 1'b1;
            end else begin
                ext_d = 1'b0;
                brk_d = 1'b0;
            end
        end
    end

    // ---------------- mode FSM ----------------
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        armed_d     = armed_q;
        entry_d     = '0;
        commit_d    = '0;
        cancel_d    = '0;
        key_valid_d = 1'b0;
        key_data_d  = key_data;
        key_ext_d   = key_ext;

        case (state_q)
            ST_IDLE: begin
                if (match_any) begin
                    state_d = HOLD_MASK[match_idx] ? ST_HOLD : ST_EDIT;
                    idx_d   = match_idx;
                    armed_d = 1'b0;
                    entry_d = onehot(match_idx);
                end
            end

            ST_EDIT: begin
                // ENTER outranks the timeout; a stale byte that lands on the
                // timeout cycle is dropped along with the mode.
                if (key_evt && rx_data == K_ENTER) begin
                    commit_d = onehot(idx_q);
                    state_d  = ST_IDLE;
`ifdef KEY_CANCEL_EN
                end else if (key_evt && rx_data == K_ESC) begin
                    cancel_d = onehot(idx_q);
                    state_d  = ST_IDLE;
`endif
                end else if (to_hit) begin
                    cancel_d = onehot(idx_q);
                    state_d  = ST_IDLE;
                end else if (key_evt) begin
                    key_valid_d = 1'b1;
                    key_data_d  = rx_data;
                    key_ext_d   = ext_q;
                end
            end

            ST_HOLD: begin
                // Release outranks everything; any byte this cycle is lost.
                if (armed_q && !hold_active) begin
                    commit_d = onehot(idx_q);
                    state_d  = ST_IDLE;
                    armed_d  = 1'b0;
`ifdef KEY_CANCEL_EN
                end else if (key_evt && rx_data == K_ESC) begin
                    cancel_d = onehot(idx_q);
                    state_d  = ST_IDLE;
                    armed_d  = 1'b0;
`endif
                end else if (hold_active) begin
                    armed_d = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                armed_d = 1'b0;
            end
        endcase

        mode_d = (state_d == ST_IDLE) ? '0 : onehot(idx_d);
    end

    // ---------------- timeout and blink counters ----------------
    always_comb begin
        to_cnt_d = rx_en ? 32'd0 : to_cnt_q + 32'd1;

        blink_cnt_d = blink_cnt_q + BW'(1);
        phase_d     = phase_q;
        if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
        end

        // Built from next-state values so led always agrees with mode.
        for (int i = 0; i < NUM_MODES; i++)
            led_d[i] = mode_d[i] ? phase_d : 1'b1;
    end

    // ---------------- registers ----------------
    always_ff @(posedge CLOCK_50) begin
        if (!nReset) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            armed_q     <= 1'b0;
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
            to_cnt_q    <= '0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
            mode        <= '0;
            entry       <= '0;
            commit      <= '0;
            cancel      <= '0;
            key_data    <= '0;
            key_ext     <= 1'b0;
            key_valid   <= 1'b0;
            led         <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            armed_q     <= armed_d;
            ext_q       <= ext_d;
            brk_q       <= brk_d;
            to_cnt_q    <= to_cnt_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            mode        <= mode_d;
            entry       <= entry_d;
            commit      <= commit_d;
            cancel      <= cancel_d;
            key_data    <= key_data_d;
            key_ext     <= key_ext_d;
            key_valid   <= key_valid_d;
            led         <= led_d;
        end
    end

endmodule

// File: tb/tb_ps2_mode_controller.sv
module tb_ps2_mode_controller;

    logic       CLOCK_50 = 1'b0;
    logic       nReset;
    logic [7:0] rx_data;
    logic       rx_en;
    logic       hold_active;
    logic [3:0] mode, entry, commit, cancel, led;
    logic [7:0] key_data;
    logic       key_ext, key_valid;

    int total = 0;
    int bad   = 0;

    always #5 CLOCK_50 = ~CLOCK_50;

    ps2_mode_controller #(
        .BLINK_DIV   (4),
        .TIMEOUT_CYC (100)
    ) dut (
        .CLOCK_50    (CLOCK_50),
        .nReset      (nReset),
        .rx_data     (rx_data),
        .rx_en       (rx_en),
        .hold_active (hold_active),
        .mode        (mode),
        .entry       (entry),
        .commit      (commit),
        .cancel      (cancel),
        .key_data    (key_data),
        .key_ext     (key_ext),
        .key_valid   (key_valid),
        .led         (led)
    );

    typedef struct {
        logic       en;
        logic [7:0] d;
        logic [3:0] mode, entry, commit, cancel;
        logic       kv;
        logic [7:0] kd;
        logic       ke;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic en, input logic [7:0] d, input logic [3:0] m,
                       input logic [3:0] en_p, input logic [3:0] cm, input logic [3:0] cn,
                       input logic kv, input logic [7:0] kd, input logic ke);
        vec_t v;
        v.en = en; v.d = d; v.mode = m; v.entry = en_p; v.commit = cm; v.cancel = cn;
        v.kv = kv; v.kd = kd; v.ke = ke;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    // Drive one cycle of inputs on the falling edge, sample just after rising.
    task automatic step(input logic en, input logic [7:0] d);
        @(negedge CLOCK_50);
        rx_en   = en;
        rx_data = d;
        @(posedge CLOCK_50);
        #1;
    endtask

    initial begin
        int first_cancel;
        int last_chg;
        int nchg;
        logic prev;
        logic hi_ok;

        nReset = 1'b0; rx_en = 1'b0; rx_data = 8'h00; hold_active = 1'b0;

        // table: edit-mode flow, prefix filtering, IDLE filtering, ESC
        add(1, 8'h4B, 4'h1, 4'h1, 4'h0, 4'h0, 0, 8'h00, 0);
        add(1, 8'h16, 4'h1, 4'h0, 4'h0, 4'h0, 1, 8'h16, 0);
        add(1, 8'h1E, 4'h1, 4'h0, 4'h0, 4'h0, 1, 8'h1E, 0);
        add(0, 8'h00, 4'h1, 4'h0, 4'h0, 4'h0, 0, 8'h1E, 0);
        add(1, 8'h5A, 4'h0, 4'h0, 4'h1, 4'h0, 0, 8'h1E, 0);
        add(0, 8'h00, 4'h0, 4'h0, 4'h0, 4'h0, 0, 8'h1E, 0);
        add(1, 8'h32, 4'h2, 4'h2, 4'h0, 4'h0, 0, 8'h1E, 0);
        add(1, 8'hF0, 4'h2, 4'h0, 4'h0, 4'h0, 0, 8'h1E, 0);
        add(1, 8'h16, 4'h2, 4'h0, 4'h0, 4'h0, 0, 8'h1E, 0);
        add(1, 8'hE0, 4'h2, 4'h0, 4'h0, 4'h0, 0, 8'h1E, 0);
        add(1, 8'h75, 4'h2, 4'h0, 4'h0, 4'h0, 1, 8'h75, 1);
        add(0, 8'h00, 4'h2, 4'h0, 4'h0, 4'h0, 0, 8'h75, 1);
        add(1, 8'h4B, 4'h2, 4'h0, 4'h0, 4'h0, 1, 8'h4B, 0);
        add(1, 8'hE0, 4'h2, 4'h0, 4'h0, 4'h0, 0, 8'h4B, 0);
        add(1, 8'hF0, 4'h2, 4'h0, 4'h0, 4'h0, 0, 8'h4B, 0);
        add(1, 8'h5A, 4'h2, 4'h0, 4'h0, 4'h0, 0, 8'h4B, 0);
        add(1, 8'h5A, 4'h0, 4'h0, 4'h2, 4'h0, 0, 8'h4B, 0);
        add(1, 8'hF0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 8'h4B, 0);
        add(1, 8'h4B, 4'h0, 4'h0, 4'h0, 4'h0, 0, 8'h4B, 0);
        add(1, 8'h16, 4'h0, 4'h0, 4'h0, 4'h0, 0, 8'h4B, 0);
        add(1, 8'h3A, 4'h4, 4'h4, 4'h0, 4'h0, 0, 8'h4B, 0);
`ifdef KEY_CANCEL_EN
        add(1, 8'h76, 4'h0, 4'h0, 4'h0, 4'h4, 0, 8'h4B, 0);
        add(0, 8'h00, 4'h0, 4'h0, 4'h0, 4'h0, 0, 8'h4B, 0);
`else
        add(1, 8'h76, 4'h4, 4'h0, 4'h0, 4'h0, 1, 8'h76, 0);
        add(1, 8'h5A, 4'h0, 4'h0, 4'h4, 4'h0, 0, 8'h76, 0);
`endif

        // reset state
        repeat (3) @(posedge CLOCK_50);
        #1;
        chk("rst_out", {mode, entry, commit, cancel, led, key_data, key_ext, key_valid},
            32'h0);
        @(negedge CLOCK_50);
        nReset = 1'b1;
        @(posedge CLOCK_50);
        #1;
        chk("rst_led_idle", {28'h0, led}, 32'hF);
        chk("rst_mode_idle", {28'h0, mode}, 32'h0);

        // table run
        foreach (vecs[i]) begin
            step(vecs[i].en, vecs[i].d);
            chk($sformatf("v%0d_mode", i),   {28'h0, mode},   {28'h0, vecs[i].mode});
            chk($sformatf("v%0d_entry", i),  {28'h0, entry},  {28'h0, vecs[i].entry});
            chk($sformatf("v%0d_commit", i), {28'h0, commit}, {28'h0, vecs[i].commit});
            chk($sformatf("v%0d_cancel", i), {28'h0, cancel}, {28'h0, vecs[i].cancel});
            chk($sformatf("v%0d_key", i), {22'h0, key_valid, key_ext, key_data},
                {22'h0, vecs[i].kv, vecs[i].ke, vecs[i].kd});
        end

        // hold mode: no early exit, arm on high, commit on fall, byte dropped
        hold_active = 1'b0;
        step(1, 8'h29);
        chk("hold_entry", {24'h0, mode, entry}, {24'h0, 4'h8, 4'h8});
        for (int k = 0; k < 10; k++) begin
            step(k == 2, 8'h16);
            chk($sformatf("hold_lo%0d", k), {23'h0, key_valid, mode, commit},
                {23'h0, 1'b0, 4'h8, 4'h0});
        end
        hold_active = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step(0, 8'h00);
            chk($sformatf("hold_hi%0d", k), {24'h0, mode, commit}, {24'h0, 4'h8, 4'h0});
        end
        hold_active = 1'b0;
        step(1, 8'h4B);
        chk("hold_release", {20'h0, mode, entry, commit}, {20'h0, 4'h0, 4'h0, 4'h8});
        step(0, 8'h00);
        chk("hold_after", {20'h0, mode, entry, commit}, {20'h0, 4'h0, 4'h0, 4'h0});

`ifdef KEY_CANCEL_EN
        // ESC cancels an unarmed hold mode
        step(1, 8'h29);
        step(1, 8'h76);
        chk("hold_esc", {24'h0, mode, cancel}, {24'h0, 4'h0, 4'h8});
`endif

        // timeout: cancel 101 samples after the last rx_en
        step(1, 8'h32);
        chk("to_entry", {28'h0, entry}, 32'h2);
        first_cancel = -1;
        for (int k = 1; k <= 200; k++) begin
            step(0, 8'h00);
            if (cancel != 4'h0) begin
                first_cancel = k;
                break;
            end
        end
        chk("to_delay", first_cancel, 101);
        chk("to_cancel", {24'h0, mode, cancel}, {24'h0, 4'h0, 4'h2});

        // blink in mode 0
        step(1, 8'h4B);
        chk("blink_entry", {28'h0, mode}, 32'h1);
        prev = led[0];
        last_chg = -1;
        nchg = 0;
        hi_ok = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step(0, 8'h00);
            if (led[3:1] !== 3'b111) hi_ok = 1'b0;
            if (led[0] !== prev) begin
                if (last_chg >= 0) chk($sformatf("blink_period%0d", nchg), k - last_chg, 4);
                last_chg = k;
                nchg++;
                prev = led[0];
            end
        end
        chk("blink_changes", nchg, 5);
        chk("blink_hi", {31'h0, hi_ok}, 32'h1);

        // reset mid-blink with a pending break prefix
        step(1, 8'hF0);
        @(negedge CLOCK_50);
        rx_en = 1'b0;
        nReset = 1'b0;
        @(posedge CLOCK_50);
        #1;
        chk("midrst_out", {mode, entry, commit, cancel, led, key_data, key_ext, key_valid},
            32'h0);
        @(negedge CLOCK_50);
        nReset = 1'b1;
        @(posedge CLOCK_50);
        #1;
        chk("midrst_led", {28'h0, led}, 32'hF);
        step(1, 8'h4B);
        chk("midrst_prefix_gone", {24'h0, mode, entry}, {24'h0, 4'h1, 4'h1});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
